// File: rtl/grid_line_clear_ctrl.sv
// Tetris line-clear sequencer: scans the row store bottom-up, drops full rows,
// compacts the remainder downward, zero-fills the vacated top rows and reports the count.
module grid_line_clear_ctrl #(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int ROW_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ROW_AW:0]   lines_cleared,
  output logic [ROW_AW-1:0] row_rd_addr,
  input  logic [COLS-1:0]   row_rd_data,
  output logic              row_wr_en,
  output logic [ROW_AW-1:0] row_wr_addr,
  output logic [COLS-1:0]   row_wr_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_FILL,
    S_DONE
  } state_e;

  localparam logic [ROW_AW:0] LAST_ROW = (ROW_AW+1)'(ROWS - 1);

  state_e          state_q, state_d;
  logic [ROW_AW:0] rd_q, rd_d;
  logic [ROW_AW:0] wr_q, wr_d;
  logic [ROW_AW:0] cnt_q, cnt_d;
  logic [ROW_AW:0] lines_q, lines_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            full;

  assign full        = &row_rd_data;
  assign row_rd_addr = rd_q[ROW_AW-1:0];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers latches.
    state_d     = state_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    lines_d     = lines_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    row_wr_en   = 1'b0;
    row_wr_addr = '0;
    row_wr_data = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_d    = LAST_ROW;
          wr_d    = LAST_ROW;
          cnt_d   = '0;
          lines_d = '0;
          busy_d  = 1'b1;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (full) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          // A row already sitting at its destination needs no rewrite.
          if (rd_q != wr_q) begin
            row_wr_en   = 1'b1;
            row_wr_addr = wr_q[ROW_AW-1:0];
            row_wr_data = row_rd_data;
          end
          wr_d = wr_q - 1'b1;
        end
        rd_d = rd_q - 1'b1;
        if (rd_q == '0) begin
          if (cnt_d == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            lines_d = cnt_d;
          end else begin
            state_d = S_FILL;
          end
        end
      end

      S_FILL: begin
        row_wr_en   = 1'b1;
        row_wr_addr = wr_q[ROW_AW-1:0];
        wr_d        = wr_q - 1'b1;
        if (wr_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          lines_d = cnt_q;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign lines_cleared = lines_q;

endmodule

// File: tb/tb_grid_line_clear_ctrl.sv
// Self-checking bench for grid_line_clear_ctrl: behavioural row store plus a
// list-based compaction model; directed and random grids.
module tb_grid_line_clear_ctrl;

  localparam int ROWS   = 16;
  localparam int COLS   = 16;
  localparam int ROW_AW = 4;

  typedef logic [COLS-1:0] grid_t [ROWS];

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              busy;
  logic              done;
  logic [ROW_AW:0]   lines_cleared;
  logic [ROW_AW-1:0] row_rd_addr;
  logic [COLS-1:0]   row_rd_data;
  logic              row_wr_en;
  logic [ROW_AW-1:0] row_wr_addr;
  logic [COLS-1:0]   row_wr_data;

  grid_t grid;
  grid_t init_grid;
  logic  load_req;
  int    wr_count;

  int n_cmp;
  int n_bad;

  grid_line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .ROW_AW(ROW_AW)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .lines_cleared(lines_cleared),
    .row_rd_addr  (row_rd_addr),
    .row_rd_data  (row_rd_data),
    .row_wr_en    (row_wr_en),
    .row_wr_addr  (row_wr_addr),
    .row_wr_data  (row_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row store: combinational read, synchronous write; the bench preloads it via load_req.
  assign row_rd_data = grid[row_rd_addr];

  always @(posedge clk) begin
    if (load_req) begin
      grid     <= init_grid;
      wr_count <= 0;
    end else if (row_wr_en) begin
      grid[row_wr_addr] <= row_wr_data;
      wr_count          <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: surviving rows keep their bottom-up order and settle at the bottom.
  task automatic model(input grid_t g, output grid_t exp_g, output int lc, output int writes);
    int t;
    t      = ROWS - 1;
    lc     = 0;
    writes = 0;
    for (int i = 0; i < ROWS; i++) exp_g[i] = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (g[r] == {COLS{1'b1}}) begin
        lc++;
      end else begin
        exp_g[t] = g[r];
        if (t != r) writes++;
        t--;
      end
    end
    writes += lc;
  endtask

  task automatic load(input grid_t g);
    init_grid = g;
    load_req  = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  task automatic run_pass(input string name, input grid_t g, input bit repulse);
    grid_t exp_g;
    int    lc, writes, edges;
    model(g, exp_g, lc, writes);
    load(g);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({name, ".busy_after_start"}, 32'(busy), 32'd1);
    edges = 0;
    while (done !== 1'b1 && edges < 3 * ROWS + 4) begin
      if (repulse && edges == 3) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      edges++;
    end
    check({name, ".latency"}, 32'(edges), 32'(ROWS + lc));
    if (done === 1'b1) begin
      check({name, ".wr_en_in_done"}, 32'(row_wr_en), 32'd0);
      check({name, ".lines_cleared"}, 32'(lines_cleared), 32'(lc));
      if (repulse) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check({name, ".done_one_cycle"}, 32'(done), 32'd0);
      check({name, ".busy_after_done"}, 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check({name, ".no_restart"}, 32'(busy), 32'd0);
      check({name, ".lines_held"}, 32'(lines_cleared), 32'(lc));
      check({name, ".write_count"}, 32'(wr_count), 32'(writes));
      for (int i = 0; i < ROWS; i++)
        check($sformatf("%s.row%0d", name, i), 32'(grid[i]), 32'(exp_g[i]));
    end
  endtask

  initial begin
    grid_t g;
    n_cmp    = 0;
    n_bad    = 0;
    start    = 1'b0;
    load_req = 1'b0;
    rst_n    = 1'b0;
    for (int i = 0; i < ROWS; i++) init_grid[i] = '0;
    #12;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.wr_en", 32'(row_wr_en), 32'd0);
    check("reset.lines", 32'(lines_cleared), 32'd0);
    check("reset.rd_addr", 32'(row_rd_addr), 32'd0);
    check("reset.wr_addr", 32'(row_wr_addr), 32'd0);
    check("reset.wr_data", 32'(row_wr_data), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < ROWS; i++) g[i] = COLS'(16'h0100 + i);
    run_pass("none_full", g, 1'b0);

    for (int i = 0; i < ROWS; i++) g[i] = COLS'(16'h0100 + i);
    g[15] = '1;
    g[14] = 16'h0001;
    run_pass("bottom_full", g, 1'b0);

    for (int i = 0; i < ROWS; i++) g[i] = COLS'(i);
    g[5] = '1;
    g[3] = '1;
    run_pass("rows5_3", g, 1'b0);

    for (int i = 0; i < ROWS; i++) g[i] = '1;
    run_pass("all_full", g, 1'b0);

    for (int i = 0; i < ROWS; i++) g[i] = COLS'(i);
    g[5] = '1;
    g[3] = '1;
    run_pass("repulse", g, 1'b1);

    // Asynchronous reset in the middle of a scan.
    for (int i = 0; i < ROWS; i++) g[i] = (i % 2 == 0) ? '1 : COLS'(i);
    load(g);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset.busy", 32'(busy), 32'd0);
    check("midreset.wr_en", 32'(row_wr_en), 32'd0);
    check("midreset.done", 32'(done), 32'd0);
    check("midreset.lines", 32'(lines_cleared), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < ROWS; i++) g[i] = COLS'(16'h0100 + i);
    run_pass("after_reset", g, 1'b0);

    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < ROWS; i++)
        g[i] = ($urandom_range(0, 2) == 0) ? '1 : COLS'($urandom);
      run_pass($sformatf("rand%0d", p), g, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
